spi_slave_responder: RTL

Responder end of the team's SPI link: a mode-0 (CPOL=0, CPHA=0), MSB-first SPI slave that runs entirely in the system `clk` domain. It oversamples `SPI_SCLK`, `SPI_CS` and `SPI_MOSI` through synchronizers, deserializes MOSI into bytes, and serializes a locally loaded byte onto MISO. It is the device-side counterpart to the existing SPI master and connects pin-to-pin to it.

---
 rtl/spi_slave_responder_if.sv | 33 +++
 rtl/spi_slave_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder_if.sv
// spi_slave_responder_if: pin and local-side signals of the SPI responder.
// slave modport is the responder view, master modport the peer/host view.
interface spi_slave_responder_if #(
  parameter int WIDTH = 8
);
  logic             SPI_SCLK;
  logic             SPI_CS;
  logic             SPI_MOSI;
  logic             SPI_MISO;
  logic [WIDTH-1:0] txData;
  logic             txLoad;
  logic             txUsed;
  logic [WIDTH-1:0] rxData;
  logic             rxValid;
  logic             busy;
  logic             frameErr;

  modport slave (
    input  SPI_SCLK, SPI_CS, SPI_MOSI,
    input  txData, txLoad,
    output SPI_MISO, txUsed,
    output rxData, rxValid,
    output busy, frameErr
  );

  modport master (
    output SPI_SCLK, SPI_CS, SPI_MOSI,
    output txData, txLoad,
    input  SPI_MISO, txUsed,
    input  rxData, rxValid,
    input  busy, frameErr
  );
endinterface

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: mode-0 MSB-first SPI slave, oversampled in clk.
// Pins are synchronized, edges detected, words shifted in and out.
module spi_slave_responder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_slave_responder_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_q;
  logic                   r_cs_q;

  logic w_sclk, w_cs, w_mosi;
  logic w_sclk_rise, w_sclk_fall;
  logic w_cs_rise, w_cs_fall;

  logic [WIDTH-1:0] r_tx_hold;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_tx_shift, w_tx_shift_nxt;
  logic [WIDTH-1:0] r_rx_shift, w_rx_shift_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_reload, w_reload_nxt;
  logic [WIDTH-1:0] r_rx_data, w_rx_data_nxt;
  logic             r_rx_valid, w_rx_valid_nxt;
  logic             r_tx_used, w_tx_used_nxt;
  logic             r_frame_err, w_frame_err_nxt;
  logic [WIDTH-1:0] w_rx_word;

  // Pin synchronizers plus one registered copy for edge detection.
  // Everything clears to 0, so a CS already low at reset release
  // produces no csFall and a held-high CS produces an ignored csRise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_q    <= 1'b0;
      r_cs_q      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.SPI_SCLK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.SPI_CS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.SPI_MOSI};
      r_sclk_q    <= w_sclk;
      r_cs_q      <= w_cs;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_q;
  assign w_sclk_fall = ~w_sclk & r_sclk_q;
  assign w_cs_rise   = w_cs & ~r_cs_q;
  assign w_cs_fall   = ~w_cs & r_cs_q;
  assign w_rx_word   = {r_rx_shift[WIDTH-2:0], w_mosi};

  // Hold register: any load is taken, the latest one wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_hold <= '0;
    end else if (bus.txLoad) begin
      r_tx_hold <= bus.txData;
    end
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_cnt       <= '0;
      r_reload    <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_used   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tx_shift  <= w_tx_shift_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_reload    <= w_reload_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_tx_used   <= w_tx_used_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Next-state: CS edges take priority over any SCLK edge.
  always_comb begin
    w_state_nxt     = r_state;
    w_tx_shift_nxt  = r_tx_shift;
    w_rx_shift_nxt  = r_rx_shift;
    w_cnt_nxt       = r_cnt;
    w_reload_nxt    = r_reload;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_tx_used_nxt   = 1'b0;
    w_frame_err_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt    = S_ACTIVE;
          w_tx_shift_nxt = r_tx_hold;
          w_tx_used_nxt  = 1'b1;
          w_cnt_nxt      = '0;
          w_reload_nxt   = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt     = S_IDLE;
          w_frame_err_nxt = (r_cnt != '0);
          w_cnt_nxt       = '0;
          w_reload_nxt    = 1'b0;
        end else if (w_sclk_rise) begin
          w_rx_shift_nxt = w_rx_word;
          if (r_cnt == CW'(WIDTH - 1)) begin
            w_rx_data_nxt  = w_rx_word;
            w_rx_valid_nxt = 1'b1;
            w_cnt_nxt      = '0;
            w_reload_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else if (w_sclk_fall) begin
          if (r_reload) begin
            w_tx_shift_nxt = r_tx_hold;
            w_tx_used_nxt  = 1'b1;
            w_reload_nxt   = 1'b0;
          end else begin
            w_tx_shift_nxt = {r_tx_shift[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy     = (r_state == S_ACTIVE);
  assign bus.SPI_MISO = bus.busy ? r_tx_shift[WIDTH-1] : 1'b0;
  assign bus.rxData   = r_rx_data;
  assign bus.rxValid  = r_rx_valid;
  assign bus.txUsed   = r_tx_used;
  assign bus.frameErr = r_frame_err;

endmodule
